// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default address map for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        SEL_BRAM = 2'd0,
        SEL_GPIO = 2'd1,
        SEL_NONE = 2'd2
    } slave_sel_t;

    localparam logic [31:0] DEF_BRAM_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_BRAM_TOP  = 32'h0000_07FF;
    localparam logic [31:0] DEF_GPIO_BASE = 32'hFFFF_FFF0;
    localparam logic [31:0] DEF_GPIO_TOP  = 32'hFFFF_FFF3;

    // Inclusive base..top test done as one unsigned compare (assumes top >= base).
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] top);
        return (addr - base) <= (top - base);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_addr_decode.sv
// Purely combinational address decoder: maps a byte address onto BRAM, GPIO or NONE.
module mem_addr_decode
    import mem_bus_arbiter_pkg::*;
#(
    parameter logic [31:0] BRAM_BASE = DEF_BRAM_BASE,
    parameter logic [31:0] BRAM_TOP  = DEF_BRAM_TOP,
    parameter logic [31:0] GPIO_BASE = DEF_GPIO_BASE,
    parameter logic [31:0] GPIO_TOP  = DEF_GPIO_TOP
) (
    input  logic [31:0] addr,
    output slave_sel_t  sel
);

    always_comb begin
        sel = SEL_NONE;
        if (in_range(addr, BRAM_BASE, BRAM_TOP)) begin
            sel = SEL_BRAM;
        end else if (in_range(addr, GPIO_BASE, GPIO_TOP)) begin
            sel = SEL_GPIO;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter giving a CPU (master 0) and a loader/debug port (master 1)
// fixed-latency access to a shared BRAM/GPIO slave bus.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter logic [31:0] BRAM_BASE = DEF_BRAM_BASE,
    parameter logic [31:0] BRAM_TOP  = DEF_BRAM_TOP,
    parameter logic [31:0] GPIO_BASE = DEF_GPIO_BASE,
    parameter logic [31:0] GPIO_TOP  = DEF_GPIO_TOP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       m_req,
    input  logic [1:0][31:0] m_addr,
    input  logic [1:0][31:0] m_wdata,
    input  logic [1:0]       m_we,
    input  logic [1:0][3:0]  m_mask,
    output logic [1:0]       m_gnt,
    output logic [1:0]       m_rvalid,
    output logic [31:0]      m_rdata,
    output logic             m_err,
    output logic [31:0]      memAddress,
    output logic [31:0]      memWriteData,
    output logic [3:0]       byteMask,
    output logic             memWrite,
    input  logic [31:0]      bramReadData,
    input  logic [31:0]      gpioReadData,
    output logic [1:0]       dbg_state
);

    // Handshake: a master raises m_req with stable fields and holds them until a
    // one-cycle m_gnt pulse; exactly two cycles after m_gnt, m_rvalid pulses with
    // m_rdata/m_err. m_req may drop any time after m_gnt without effect.

    arb_state_t state;
    logic       rr_ptr;
    logic       cur;
    logic       lat_we;
    slave_sel_t sel_q;
    logic       winner;
    slave_sel_t win_sel;
    logic [31:0] resp_rdata;

    assign winner    = (m_req == 2'b11) ? rr_ptr : m_req[1];
    assign dbg_state = state;

    mem_addr_decode #(
        .BRAM_BASE(BRAM_BASE),
        .BRAM_TOP (BRAM_TOP),
        .GPIO_BASE(GPIO_BASE),
        .GPIO_TOP (GPIO_TOP)
    ) u_decode (
        .addr(m_addr[winner]),
        .sel (win_sel)
    );

    // Slave data is sampled in RESP, one cycle after the address went out.
    always_comb begin
        resp_rdata = '0;
        if (!lat_we) begin
            case (sel_q)
                SEL_BRAM: resp_rdata = bramReadData;
                SEL_GPIO: resp_rdata = gpioReadData;
                default:  resp_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            cur          <= 1'b0;
            lat_we       <= 1'b0;
            sel_q        <= SEL_NONE;
            m_gnt        <= 2'b00;
            m_rvalid     <= 2'b00;
            m_err        <= 1'b0;
            m_rdata      <= '0;
            memWrite     <= 1'b0;
            memAddress   <= '0;
            memWriteData <= '0;
            byteMask     <= 4'b0000;
        end else begin
            m_gnt    <= 2'b00;
            m_rvalid <= 2'b00;
            m_err    <= 1'b0;
            memWrite <= 1'b0;
            case (state)
                IDLE: begin
                    if (|m_req) begin
                        m_gnt        <= winner ? 2'b10 : 2'b01;
                        cur          <= winner;
                        rr_ptr       <= ~winner;
                        memAddress   <= m_addr[winner];
                        memWriteData <= m_wdata[winner];
                        byteMask     <= m_mask[winner];
                        lat_we       <= m_we[winner];
                        sel_q        <= win_sel;
                        memWrite     <= m_we[winner] && (win_sel != SEL_NONE);
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                end
                RESP: begin
                    m_rvalid <= cur ? 2'b10 : 2'b01;
                    m_err    <= (sel_q == SEL_NONE);
                    m_rdata  <= resp_rdata;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: transaction-level model plus directed vectors.
module tb_mem_bus_arbiter;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       m_req = '0;
    logic [1:0][31:0] m_addr = '0;
    logic [1:0][31:0] m_wdata = '0;
    logic [1:0]       m_we = '0;
    logic [1:0][3:0]  m_mask = '0;
    logic [1:0]       m_gnt;
    logic [1:0]       m_rvalid;
    logic [31:0]      m_rdata;
    logic             m_err;
    logic [31:0]      memAddress;
    logic [31:0]      memWriteData;
    logic [3:0]       byteMask;
    logic             memWrite;
    logic [31:0]      bramReadData = '0;
    logic [31:0]      gpioReadData = '0;
    logic [1:0]       dbg_state;

    mem_bus_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .m_req        (m_req),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_we         (m_we),
        .m_mask       (m_mask),
        .m_gnt        (m_gnt),
        .m_rvalid     (m_rvalid),
        .m_rdata      (m_rdata),
        .m_err        (m_err),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .byteMask     (byteMask),
        .memWrite     (memWrite),
        .bramReadData (bramReadData),
        .gpioReadData (gpioReadData),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mw_cnt = 0;
    int rv_cnt = 0;

    // ---------------- behavioural model ----------------
    bit          pend = 1'b0;
    int          g = 0;
    int          pm = 0;
    logic [31:0] pa = '0;
    logic        pwe = 1'b0;
    logic        perr = 1'b0;
    logic        favour = 1'b0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_mask = '0;
    logic [31:0] exp_q[$];

    function automatic bit is_bram(input logic [31:0] a);
        return a <= 32'h0000_07FF;
    endfunction

    function automatic bit is_gpio(input logic [31:0] a);
        return (a >= 32'hFFFF_FFF0) && (a <= 32'hFFFF_FFF3);
    endfunction

    function automatic void model_reset();
        pend       = 1'b0;
        favour     = 1'b0;
        last_addr  = '0;
        last_wdata = '0;
        last_mask  = '0;
        exp_q.delete();
    endfunction

    // Transaction view: a request seen while the bus is free is granted at that
    // edge, completes two edges later, and the bus is free again one edge after.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!reset) begin
            if (pend && cyc == g + 2) begin
                if (pwe || perr)   exp_q.push_back(32'h0);
                else if (is_bram(pa)) exp_q.push_back(bramReadData);
                else               exp_q.push_back(gpioReadData);
            end
            if ((!pend || cyc >= g + 3) && m_req != 2'b00) begin
                pm         = (m_req == 2'b11) ? int'(favour) : int'(m_req[1]);
                favour     = (pm == 0);
                pend       = 1'b1;
                g          = cyc;
                pa         = m_addr[pm];
                pwe        = m_we[pm];
                perr       = !(is_bram(pa) || is_gpio(pa));
                last_addr  = pa;
                last_wdata = m_wdata[pm];
                last_mask  = m_mask[pm];
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        logic [1:0] eg;
        logic [1:0] erv;
        logic       emw;
        @(negedge clk);
        eg  = (pend && cyc == g)     ? (2'b01 << pm) : 2'b00;
        erv = (pend && cyc == g + 2) ? (2'b01 << pm) : 2'b00;
        emw = pend && cyc == g && pwe && !perr;
        chk("m_gnt", {30'd0, m_gnt}, {30'd0, eg});
        chk("m_rvalid", {30'd0, m_rvalid}, {30'd0, erv});
        chk("memWrite", {31'd0, memWrite}, {31'd0, emw});
        chk("m_err", {31'd0, m_err}, {31'd0, (erv != 2'b00) && perr});
        chk("memAddress", memAddress, last_addr);
        chk("memWriteData", memWriteData, last_wdata);
        chk("byteMask", {28'd0, byteMask}, {28'd0, last_mask});
        if (erv != 2'b00) begin
            if (exp_q.size() == 0) chk("exp_q_empty", 32'd0, 32'd1);
            else                   chk("m_rdata", m_rdata, exp_q.pop_front());
        end
        if (memWrite === 1'b1) mw_cnt++;
        if (m_rvalid !== 2'b00) rv_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        m_req = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic issue(input int m, input logic [31:0] a, input logic we,
                         input logic [31:0] wd, input logic [3:0] mk, output int gcyc);
        @(negedge clk);
        m_req[m]   = 1'b1;
        m_addr[m]  = a;
        m_we[m]    = we;
        m_wdata[m] = wd;
        m_mask[m]  = mk;
        gcyc = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_gnt[m] === 1'b1) begin
                gcyc = cyc;
                break;
            end
        end
        m_req[m] = 1'b0;
        if (gcyc < 0) chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rvalid(output int rcyc, output logic [1:0] rv,
                               output logic [31:0] rd, output logic e);
        rcyc = -1; rv = '0; rd = '0; e = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_rvalid !== 2'b00) begin
                rcyc = cyc; rv = m_rvalid; rd = m_rdata; e = m_err;
                break;
            end
        end
        if (rcyc < 0) chk("rvalid_timeout", 32'd0, 32'd1);
    endtask

    task automatic xact(input string name, input int m, input logic [31:0] a,
                        input logic we, input logic [31:0] wd, input logic [3:0] mk,
                        input logic [31:0] exp_rd, input logic exp_e);
        int gc, rc;
        logic [1:0] rv;
        logic [31:0] rd;
        logic e;
        issue(m, a, we, wd, mk, gc);
        wait_rvalid(rc, rv, rd, e);
        chk({name, "_lat"}, rc - gc, 32'd2);
        chk({name, "_rv"}, {30'd0, rv}, (m == 1) ? 32'd2 : 32'd1);
        chk({name, "_rdata"}, rd, exp_rd);
        chk({name, "_err"}, {31'd0, e}, {31'd0, exp_e});
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int gc, rc, n;
        int gcycs[4];
        int gms[4];
        logic [1:0] rv;
        logic [31:0] rd;
        logic e;

        do_reset();
        chk("rst_gnt", {30'd0, m_gnt}, 32'd0);
        chk("rst_rvalid", {30'd0, m_rvalid}, 32'd0);
        chk("rst_memWrite", {31'd0, memWrite}, 32'd0);
        chk("rst_memAddress", memAddress, 32'd0);
        chk("rst_byteMask", {28'd0, byteMask}, 32'd0);
        chk("rst_rdata", m_rdata, 32'd0);
        chk("rst_err", {31'd0, m_err}, 32'd0);

        // Basic BRAM read from the CPU.
        bramReadData = 32'hDEAD_BEEF;
        gpioReadData = 32'h1234_5678;
        issue(0, 32'h0000_0010, 1'b0, 32'h0, 4'hF, gc);
        @(negedge clk);
        chk("read_addr_n1", memAddress, 32'h0000_0010);
        wait_rvalid(rc, rv, rd, e);
        chk("read_lat", rc - gc, 32'd2);
        chk("read_rv", {30'd0, rv}, 32'd1);
        chk("read_rdata", rd, 32'hDEAD_BEEF);
        chk("read_err", {31'd0, e}, 32'd0);

        // GPIO write from the loader: single memWrite pulse, rdata forced to 0.
        repeat (2) @(negedge clk);
        mw_cnt = 0;
        xact("gpio_wr", 1, 32'hFFFF_FFF0, 1'b1, 32'h0000_0001, 4'b0001, 32'h0, 1'b0);
        chk("gpio_wr_mw_cnt", mw_cnt, 32'd1);

        // Unmapped write: no strobe, error flagged.
        repeat (2) @(negedge clk);
        mw_cnt = 0;
        xact("unmap_wr", 0, 32'h0000_1000, 1'b1, 32'h0000_00AA, 4'hF, 32'h0, 1'b1);
        chk("unmap_wr_mw_cnt", mw_cnt, 32'd0);

        // Decode boundaries.
        bramReadData = 32'hB0B0_0001;
        gpioReadData = 32'h6060_0002;
        xact("bnd_7ff", 0, 32'h0000_07FF, 1'b0, 32'h0, 4'hF, 32'hB0B0_0001, 1'b0);
        xact("bnd_800", 0, 32'h0000_0800, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1);
        xact("bnd_ff3", 1, 32'hFFFF_FFF3, 1'b0, 32'h0, 4'hF, 32'h6060_0002, 1'b0);
        xact("bnd_fef", 1, 32'hFFFF_FFEF, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1);

        // Both masters requesting continuously: alternate starting with master 0.
        do_reset();
        @(negedge clk);
        m_addr[0] = 32'h0000_0100; m_we[0] = 1'b0; m_mask[0] = 4'hF;
        m_addr[1] = 32'h0000_0104; m_we[1] = 1'b0; m_mask[1] = 4'h3;
        m_req = 2'b11;
        n = 0;
        for (int i = 0; i < 20 && n < 4; i++) begin
            @(negedge clk);
            if (m_gnt !== 2'b00) begin
                gcycs[n] = cyc;
                gms[n]   = (m_gnt === 2'b10) ? 1 : 0;
                n++;
            end
        end
        m_req = 2'b00;
        chk("rr_count", n, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_master%0d", i), gms[i], i % 2);
            if (i > 0) chk($sformatf("rr_gap%0d", i), gcycs[i] - gcycs[i-1], 32'd3);
        end
        repeat (4) @(negedge clk);

        // Reset during the ACCESS cycle of a write abandons it.
        issue(0, 32'h0000_0020, 1'b1, 32'h5555_AAAA, 4'hF, gc);
        #2;
        reset = 1'b1;
        model_reset();
        mw_cnt = 0;
        rv_cnt = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_mw_cnt", mw_cnt, 32'd0);
        chk("rst_mid_rv_cnt", rv_cnt, 32'd0);
        m_req = 2'b11;
        gc = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_gnt !== 2'b00) begin
                gc = cyc;
                chk("rst_mid_first_gnt", {30'd0, m_gnt}, 32'd1);
                break;
            end
        end
        m_req = 2'b00;
        if (gc < 0) chk("rst_mid_gnt_timeout", 32'd0, 32'd1);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
